// File: rtl/counter_cmd_sched.sv
// Command scheduler sharing one up/down counter between two requesters.
// Requesters issue LOAD / RUN-N / WAIT-N commands over valid/ready; the block
// arbitrates round-robin, drives the counter pins and returns the counter
// value in a one-cycle completion response.
module counter_cmd_sched #(
    parameter int unsigned DW = 4,
    parameter int unsigned SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cmd_valid,
    output logic [1:0]    cmd_ready,
    input  logic [1:0]    cmd_op0,
    input  logic [1:0]    cmd_op1,
    input  logic          cmd_dir0,
    input  logic          cmd_dir1,
    input  logic [DW-1:0] cmd_data0,
    input  logic [DW-1:0] cmd_data1,
    input  logic [SW-1:0] cmd_steps0,
    input  logic [SW-1:0] cmd_steps1,
    input  logic          abort,
    output logic          cnt_load,
    output logic [DW-1:0] cnt_d,
    output logic          cnt_up,
    output logic          cnt_hold,
    input  logic [DW-1:0] cnt_q,
    output logic          busy,
    output logic          resp_valid,
    output logic          resp_id,
    output logic [DW-1:0] resp_q,
    output logic          resp_abort
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_WAIT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic            owner, owner_nxt;
    logic            dir_r, dir_nxt;
    logic [SW-1:0]   remain, remain_nxt;

    logic [1:0]      grant;
    logic            acc_id;
    logic [1:0]      acc_op;
    logic            acc_dir;
    logic [DW-1:0]   acc_data;
    logic [SW-1:0]   acc_steps;

    logic            load_nxt;
    logic [DW-1:0]   d_nxt;
    logic            up_nxt;
    logic            hold_nxt;
    logic            busy_nxt;
    logic            rvalid_nxt;
    logic            rid_nxt;
    logic            rabort_nxt;

    // Round-robin grant and combinational accept; reset suppresses any transfer.
    always_comb begin
        grant = cmd_valid;
        if (cmd_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        cmd_ready = (state == S_IDLE && !rst) ? grant : 2'b00;
        acc_id    = cmd_ready[1];
        acc_op    = acc_id ? cmd_op1    : cmd_op0;
        acc_dir   = acc_id ? cmd_dir1   : cmd_dir0;
        acc_data  = acc_id ? cmd_data1  : cmd_data0;
        acc_steps = acc_id ? cmd_steps1 : cmd_steps0;
    end

    // Next state, command context and next values of the registered outputs.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        dir_nxt        = dir_r;
        remain_nxt     = remain;
        rabort_nxt     = 1'b0;
        d_nxt          = '0;

        case (state)
            S_IDLE: begin
                if (|cmd_ready) begin
                    last_grant_nxt = acc_id;
                    owner_nxt      = acc_id;
                    dir_nxt        = acc_dir;
                    remain_nxt     = acc_steps;
                    case (acc_op)
                        OP_LOAD: begin
                            state_nxt = S_LOAD;
                            d_nxt     = acc_data;
                        end
                        OP_RUN:  state_nxt = (acc_steps != '0) ? S_RUN  : S_DONE;
                        OP_WAIT: state_nxt = (acc_steps != '0) ? S_WAIT : S_DONE;
                        default: begin
                            state_nxt  = S_DONE;
                            remain_nxt = '0;
                        end
                    endcase
                end
            end
            S_LOAD: state_nxt = S_DONE;
            S_RUN, S_WAIT: begin
                // The current cycle always counts; abort only shortens what follows.
                if (abort || remain == SW'(1)) begin
                    state_nxt  = S_DONE;
                    remain_nxt = '0;
                    rabort_nxt = abort;
                end else begin
                    remain_nxt = remain - SW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        load_nxt   = (state_nxt == S_LOAD);
        hold_nxt   = (state_nxt != S_RUN);
        up_nxt     = (state_nxt == S_RUN) ? dir_nxt : cnt_up;
        busy_nxt   = (state_nxt != S_IDLE);
        rvalid_nxt = (state_nxt == S_DONE);
        rid_nxt    = rvalid_nxt ? owner_nxt : 1'b0;
    end

    // State, context and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            dir_r      <= 1'b1;
            remain     <= '0;
            cnt_load   <= 1'b0;
            cnt_d      <= '0;
            cnt_up     <= 1'b1;
            cnt_hold   <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            dir_r      <= dir_nxt;
            remain     <= remain_nxt;
            cnt_load   <= load_nxt;
            cnt_d      <= d_nxt;
            cnt_up     <= up_nxt;
            cnt_hold   <= hold_nxt;
            busy       <= busy_nxt;
            resp_valid <= rvalid_nxt;
            resp_id    <= rid_nxt;
            resp_abort <= rabort_nxt;
        end
    end

    // Counter value is only settled in the DONE cycle, so pass it through then.
    assign resp_q = resp_valid ? cnt_q : '0;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Bench for counter_cmd_sched: directed table, multi-cycle corner sequences
// and randomized commands against a transaction-level expectation model.
module tb_counter_cmd_sched;

    localparam int unsigned DW = 4;
    localparam int unsigned SW = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_WAIT = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef struct {
        logic [1:0]    op;
        logic          dir;
        logic [DW-1:0] data;
        logic [SW-1:0] steps;
        int            ab_after;   // abort after this many busy cycles, -1 = none
    } cmd_t;

    typedef struct {
        int            lat;
        int            holds;
        logic [DW-1:0] q;
        logic          ab;
        logic          up;
    } exp_t;

    typedef struct {
        logic id;
        cmd_t c;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cmd_valid = 2'b00;
    logic [1:0]    cmd_ready;
    logic [1:0]    cmd_op0 = 2'b00, cmd_op1 = 2'b00;
    logic          cmd_dir0 = 1'b0, cmd_dir1 = 1'b0;
    logic [DW-1:0] cmd_data0 = '0, cmd_data1 = '0;
    logic [SW-1:0] cmd_steps0 = '0, cmd_steps1 = '0;
    logic          abort = 1'b0;
    logic          cnt_load;
    logic [DW-1:0] cnt_d;
    logic          cnt_up;
    logic          cnt_hold;
    logic [DW-1:0] cnt_q;
    logic          busy;
    logic          resp_valid;
    logic          resp_id;
    logic [DW-1:0] resp_q;
    logic          resp_abort;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q  = '0;
    logic          model_up = 1'b1;
    logic          tb_last  = 1'b1;

    always #5 clk = ~clk;

    counter_cmd_sched #(.DW(DW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op0    (cmd_op0),
        .cmd_op1    (cmd_op1),
        .cmd_dir0   (cmd_dir0),
        .cmd_dir1   (cmd_dir1),
        .cmd_data0  (cmd_data0),
        .cmd_data1  (cmd_data1),
        .cmd_steps0 (cmd_steps0),
        .cmd_steps1 (cmd_steps1),
        .abort      (abort),
        .cnt_load   (cnt_load),
        .cnt_d      (cnt_d),
        .cnt_up     (cnt_up),
        .cnt_hold   (cnt_hold),
        .cnt_q      (cnt_q),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_abort (resp_abort)
    );

    // Plain binary up/down counter standing in for the shared counter instance.
    logic [DW-1:0] ctr = '0;
    always_ff @(posedge clk) begin
        if (cnt_load)
            ctr <= cnt_d;
        else if (!cnt_hold)
            ctr <= cnt_up ? ctr + 4'd1 : ctr - 4'd1;
    end
    assign cnt_q = ctr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outcome of one command from the command rules, in cycles and values.
    function automatic exp_t model(cmd_t c, logic [DW-1:0] q, logic up);
        exp_t e;
        int   eff;
        e.lat = 1; e.holds = 0; e.q = q; e.ab = 1'b0; e.up = up;
        case (c.op)
            OP_LOAD: begin
                e.lat = 2;
                e.q   = c.data;
            end
            OP_RUN, OP_WAIT: begin
                if (c.steps != 8'd0) begin
                    if (c.ab_after >= 0 && c.ab_after < int'(c.steps)) begin
                        eff  = c.ab_after + 1;
                        e.ab = 1'b1;
                    end else begin
                        eff = int'(c.steps);
                    end
                    e.lat = 1 + eff;
                    if (c.op == OP_RUN) begin
                        e.holds = eff;
                        e.up    = c.dir;
                        e.q     = c.dir ? 4'(int'(q) + eff) : 4'(int'(q) - eff);
                    end
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(logic id, logic [1:0] op, logic dir, logic [DW-1:0] data,
                                logic [SW-1:0] steps, int ab_after, int lat, int holds,
                                logic [DW-1:0] q, logic ab, logic up);
        vec_t v;
        v.id = id;
        v.c.op = op; v.c.dir = dir; v.c.data = data; v.c.steps = steps; v.c.ab_after = ab_after;
        v.e.lat = lat; v.e.holds = holds; v.e.q = q; v.e.ab = ab; v.e.up = up;
        return v;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op    = 2'($urandom_range(0, 3));
        c.dir   = 1'($urandom_range(0, 1));
        c.data  = 4'($urandom_range(0, 15));
        c.steps = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(10, 25)) : 8'($urandom_range(0, 6));
        c.ab_after = -1;
        if ($urandom_range(0, 2) == 0)
            c.ab_after = (c.op == OP_LOAD) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, int'(c.steps)));
        return c;
    endfunction

    // Present commands, confirm the grant, follow the command to its response.
    task automatic do_cmd(input cmd_t c0, input cmd_t c1, input logic [1:0] vmask,
                          input exp_t e_tab, input bit use_tab);
        logic          g;
        logic [1:0]    exp_rdy;
        cmd_t          c;
        exp_t          e;
        int            lat, holds, loads;
        bit            seen;
        logic [DW-1:0] dseen, r_q;
        logic          r_id, r_ab, r_busy, r_up;
        @(negedge clk);
        cmd_op0 = c0.op; cmd_dir0 = c0.dir; cmd_data0 = c0.data; cmd_steps0 = c0.steps;
        cmd_op1 = c1.op; cmd_dir1 = c1.dir; cmd_data1 = c1.data; cmd_steps1 = c1.steps;
        cmd_valid = vmask;
        g = (vmask == 2'b11) ? ~tb_last : vmask[1];
        exp_rdy = g ? 2'b10 : 2'b01;
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        c = g ? c1 : c0;
        e = use_tab ? e_tab : model(c, model_q, model_up);
        @(posedge clk);
        tb_last = g;
        lat = 0; holds = 0; loads = 0; seen = 0; dseen = '0;
        r_q = '0; r_id = 1'b0; r_ab = 1'b0; r_busy = 1'b0; r_up = 1'b0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(negedge clk);
            cmd_valid = 2'b00;
            abort = (c.ab_after >= 0) && (k == c.ab_after + 1);
            #1;
            if (k == 1) r_busy = busy;
            if (!cnt_hold) holds++;
            if (cnt_load) begin
                loads++;
                dseen = cnt_d;
            end
            if (resp_valid) begin
                seen = 1; lat = k;
                r_q = resp_q; r_id = resp_id; r_ab = resp_abort; r_up = cnt_up;
            end
        end
        abort = 1'b0;
        check("resp_seen", 32'(seen), 32'(1));
        check("latency", 32'(lat), 32'(e.lat));
        check("hold_low_cycles", 32'(holds), 32'(e.holds));
        check("load_pulses", 32'(loads), 32'(c.op == OP_LOAD));
        if (c.op == OP_LOAD) check("cnt_d", 32'(dseen), 32'(c.data));
        check("resp_q", 32'(r_q), 32'(e.q));
        check("resp_id", 32'(r_id), 32'(g));
        check("resp_abort", 32'(r_ab), 32'(e.ab));
        check("busy", 32'(r_busy), 32'(1));
        check("cnt_up", 32'(r_up), 32'(e.up));
        model_q  = e.q;
        model_up = e.up;
    endtask

    initial begin
        vec_t tab [13];
        cmd_t idle_c, a, b;
        exp_t no_e;
        logic [1:0] vm;
        int ng, nresp;

        tab[0]  = mk(1'b0, OP_LOAD, 1'b0, 4'd5,  8'd0,   -1, 2, 0, 4'd5,  1'b0, 1'b1);
        tab[1]  = mk(1'b0, OP_RUN,  1'b1, 4'd0,  8'd3,   -1, 4, 3, 4'd8,  1'b0, 1'b1);
        tab[2]  = mk(1'b1, OP_LOAD, 1'b0, 4'd0,  8'd0,   -1, 2, 0, 4'd0,  1'b0, 1'b1);
        tab[3]  = mk(1'b1, OP_RUN,  1'b0, 4'd0,  8'd4,    2, 4, 3, 4'd13, 1'b1, 1'b0);
        tab[4]  = mk(1'b0, OP_RUN,  1'b1, 4'd0,  8'd0,   -1, 1, 0, 4'd13, 1'b0, 1'b0);
        tab[5]  = mk(1'b1, OP_WAIT, 1'b1, 4'd0,  8'd2,   -1, 3, 0, 4'd13, 1'b0, 1'b0);
        tab[6]  = mk(1'b0, OP_RSV,  1'b1, 4'd0,  8'd5,   -1, 1, 0, 4'd13, 1'b0, 1'b0);
        tab[7]  = mk(1'b1, OP_RUN,  1'b1, 4'd0,  8'd1,   -1, 2, 1, 4'd14, 1'b0, 1'b1);
        tab[8]  = mk(1'b0, OP_WAIT, 1'b0, 4'd0,  8'd3,    0, 2, 0, 4'd14, 1'b1, 1'b1);
        tab[9]  = mk(1'b0, OP_LOAD, 1'b0, 4'd15, 8'd0,    0, 2, 0, 4'd15, 1'b0, 1'b1);
        tab[10] = mk(1'b1, OP_RUN,  1'b1, 4'd0,  8'd2,   -1, 3, 2, 4'd1,  1'b0, 1'b1);
        tab[11] = mk(1'b0, OP_RUN,  1'b0, 4'd0,  8'd5,    4, 6, 5, 4'd12, 1'b1, 1'b0);
        tab[12] = mk(1'b1, OP_RUN,  1'b0, 4'd0,  8'd255,  3, 5, 4, 4'd8,  1'b1, 1'b0);

        idle_c.op = OP_WAIT; idle_c.dir = 1'b0; idle_c.data = '0; idle_c.steps = '0; idle_c.ab_after = -1;
        no_e.lat = 0; no_e.holds = 0; no_e.q = '0; no_e.ab = 1'b0; no_e.up = 1'b0;

        // Reset values while rst is held high.
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready",  32'(cmd_ready),  32'(0));
        check("rst_cnt_load",   32'(cnt_load),   32'(0));
        check("rst_cnt_d",      32'(cnt_d),      32'(0));
        check("rst_cnt_up",     32'(cnt_up),     32'(1));
        check("rst_cnt_hold",   32'(cnt_hold),   32'(1));
        check("rst_busy",       32'(busy),       32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_id",    32'(resp_id),    32'(0));
        check("rst_resp_q",     32'(resp_q),     32'(0));
        check("rst_resp_abort", 32'(resp_abort), 32'(0));
        rst = 1'b0;

        // Both requesters held valid out of reset: grants alternate starting with 0.
        @(negedge clk);
        cmd_op0 = OP_RUN; cmd_steps0 = '0;
        cmd_op1 = OP_RUN; cmd_steps1 = '0;
        cmd_valid = 2'b11;
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            #1;
            check("ready_not_both", 32'(cmd_ready == 2'b11), 32'(0));
            if (cmd_ready != 2'b00) begin
                check("tie_grant", 32'(cmd_ready[1]), 32'(ng % 2));
                ng++;
            end
            @(negedge clk);
        end
        cmd_valid = 2'b00;
        check("tie_grant_count", 32'(ng), 32'(4));
        tb_last = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            if (tab[i].id)
                do_cmd(idle_c, tab[i].c, 2'b10, tab[i].e, 1'b1);
            else
                do_cmd(tab[i].c, idle_c, 2'b01, tab[i].e, 1'b1);
        end

        // Reset in the middle of a long WAIT.
        @(negedge clk);
        cmd_op0 = OP_WAIT; cmd_steps0 = 8'd10; cmd_valid = 2'b01;
        #1;
        check("rstseq_ready", 32'(cmd_ready), 32'(2'b01));
        @(negedge clk);
        cmd_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstseq_busy",       32'(busy),       32'(0));
        check("rstseq_cnt_hold",   32'(cnt_hold),   32'(1));
        check("rstseq_resp_valid", 32'(resp_valid), 32'(0));
        check("rstseq_cnt_load",   32'(cnt_load),   32'(0));
        cmd_valid = 2'b11;
        #1;
        check("rstseq_ready_prio", 32'(cmd_ready), 32'(2'b01));
        cmd_valid = 2'b00;
        nresp = 0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (resp_valid) nresp++;
        end
        check("rstseq_no_resp", 32'(nresp), 32'(0));
        tb_last  = 1'b1;
        model_up = 1'b1;

        // Randomized commands, single and contending requesters.
        for (int i = 0; i < 60; i++) begin
            a = rand_cmd();
            b = rand_cmd();
            vm = ($urandom_range(0, 1) == 1) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
            do_cmd(a, b, vm, no_e, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
